// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: valid/ready write side, prefetching read side into a 2-entry skid buffer.
// Optional almost-full/almost-empty flags are enabled by defining FIFO_SYNC_CTRL_ALMOST_EN.
module fifo_sync_ctrl #(
  parameter int unsigned SIZE_DATA  = 8,
  parameter int unsigned SIZE_DEPTH = 16,
  parameter int unsigned SIZE_ADDR  = 4
`ifdef FIFO_SYNC_CTRL_ALMOST_EN
  ,
  parameter int unsigned ALMOST_FULL_TH  = 14,
  parameter int unsigned ALMOST_EMPTY_TH = 2
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic [SIZE_DATA-1:0] o_rd_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [SIZE_ADDR+1:0] o_count,
  output logic                 o_mem_wr_en,
  output logic [SIZE_ADDR-1:0] o_mem_wr_addr,
  output logic [SIZE_DATA-1:0] o_mem_wr_data,
  output logic                 o_mem_rd_en,
  output logic [SIZE_ADDR-1:0] o_mem_rd_addr,
  input  logic [SIZE_DATA-1:0] i_mem_rd_data
`ifdef FIFO_SYNC_CTRL_ALMOST_EN
  ,
  output logic                 o_almost_full,
  output logic                 o_almost_empty
`endif
);

  localparam int unsigned PTR_W = SIZE_ADDR + 1;
  localparam int unsigned CNT_W = SIZE_ADDR + 2;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     mem_count;
  logic                 pending_q, pending_d;
  skid_state_e          skid_q, skid_d;
  logic [SIZE_DATA-1:0] head_q, head_d;
  logic [SIZE_DATA-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 mem_full;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic [2:0]           skid_after;

  // Handshakes, flags and memory port drive
  always_comb begin
    mem_count     = wr_ptr_q - rd_ptr_q;
    mem_full      = (mem_count == PTR_W'(SIZE_DEPTH));
    o_wr_ready    = !mem_full;
    push          = i_wr_valid && !mem_full;
    o_rd_valid    = (skid_q != SKID_EMPTY);
    pop           = o_rd_valid && i_rd_ready;
    // Skid occupancy after this cycle, counting the read already in flight
    skid_after    = {1'b0, skid_q} + 3'(pending_q) - 3'(pop);
    issue         = (mem_count != '0) && (skid_after <= 3'd1);
    o_mem_wr_en   = push;
    o_mem_wr_addr = wr_ptr_q[SIZE_ADDR-1:0];
    o_mem_wr_data = i_wr_data;
    o_mem_rd_en   = issue;
    o_mem_rd_addr = rd_ptr_q[SIZE_ADDR-1:0];
    o_rd_data     = head_q;
    o_full        = mem_full;
    o_empty       = (count_q == '0);
    o_count       = count_q;
  end

  // Next state: pointers, occupancy and skid buffer
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(issue);
    pending_d = issue;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    skid_d    = skid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    case (skid_q)
      SKID_EMPTY: begin
        if (pending_q) begin
          head_d = i_mem_rd_data;
          skid_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        case ({pending_q, pop})
          2'b10: begin
            tail_d = i_mem_rd_data;
            skid_d = SKID_TWO;
          end
          2'b11:   head_d = i_mem_rd_data;
          2'b01:   skid_d = SKID_EMPTY;
          default: skid_d = SKID_ONE;
        endcase
      end
      SKID_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (pending_q) begin
            tail_d = i_mem_rd_data;
          end else begin
            skid_d = SKID_ONE;
          end
        end
      end
      default: skid_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= 1'b0;
      skid_q    <= SKID_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      skid_q    <= skid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

`ifdef FIFO_SYNC_CTRL_ALMOST_EN
  always_comb begin
    o_almost_full  = (count_q >= CNT_W'(ALMOST_FULL_TH));
    o_almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY_TH));
  end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench for fifo_sync_ctrl with a registered-read memory model and a word scoreboard.
module tb_fifo_sync_ctrl;

  logic       clk;
  logic       i_rst;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic [7:0] i_wr_data;
  logic       o_rd_valid;
  logic       i_rd_ready;
  logic [7:0] o_rd_data;
  logic       o_full;
  logic       o_empty;
  logic [5:0] o_count;
  logic       o_mem_wr_en;
  logic [3:0] o_mem_wr_addr;
  logic [7:0] o_mem_wr_data;
  logic       o_mem_rd_en;
  logic [3:0] o_mem_rd_addr;
  logic [7:0] mem_rd_data;
`ifdef FIFO_SYNC_CTRL_ALMOST_EN
  logic       o_almost_full;
  logic       o_almost_empty;
`endif

  fifo_sync_ctrl dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_wr_valid    (i_wr_valid),
    .o_wr_ready    (o_wr_ready),
    .i_wr_data     (i_wr_data),
    .o_rd_valid    (o_rd_valid),
    .i_rd_ready    (i_rd_ready),
    .o_rd_data     (o_rd_data),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_count       (o_count),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_wr_addr (o_mem_wr_addr),
    .o_mem_wr_data (o_mem_wr_data),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (mem_rd_data)
`ifdef FIFO_SYNC_CTRL_ALMOST_EN
    ,
    .o_almost_full (o_almost_full),
    .o_almost_empty(o_almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with a registered read port
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (o_mem_wr_en) mem[o_mem_wr_addr] <= o_mem_wr_data;
    if (o_mem_rd_en) mem_rd_data <= mem[o_mem_rd_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  logic       s_rd_valid, s_wr_ready, s_full, s_empty;
  logic       s_mem_wr_en, s_mem_rd_en, s_pushed, s_popped;
  logic [7:0] s_rd_data;
  logic [5:0] s_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_rd_valid",    32'(o_rd_valid), 32'd0);
    chk("rst_wr_ready",    32'(o_wr_ready), 32'd1);
    chk("rst_full",        32'(o_full), 32'd0);
    chk("rst_empty",       32'(o_empty), 32'd1);
    chk("rst_count",       32'(o_count), 32'd0);
    chk("rst_mem_wr_en",   32'(o_mem_wr_en), 32'd0);
    chk("rst_mem_rd_en",   32'(o_mem_rd_en), 32'd0);
    chk("rst_mem_wr_addr", 32'(o_mem_wr_addr), 32'd0);
    chk("rst_mem_rd_addr", 32'(o_mem_rd_addr), 32'd0);
    chk("rst_rd_data",     32'(o_rd_data), 32'd0);
`ifdef FIFO_SYNC_CTRL_ALMOST_EN
    chk("rst_almost_full",  32'(o_almost_full), 32'd0);
    chk("rst_almost_empty", 32'(o_almost_empty), 32'd1);
`endif
  endtask

  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    i_wr_data  = 8'h00;
    i_rst      = 1'b1;
    #1;
    if (check_vals) chk_reset_vals();
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // One cycle: check occupancy, drive inputs, sample, score the handshakes
  task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr);
    @(negedge clk);
    chk("count", 32'(o_count), 32'(q.size()));
    chk("empty", 32'(o_empty), 32'(q.size() == 0));
`ifdef FIFO_SYNC_CTRL_ALMOST_EN
    chk("almost_full",  32'(o_almost_full), 32'(q.size() >= 14));
    chk("almost_empty", 32'(o_almost_empty), 32'(q.size() <= 2));
`endif
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_ready = rr;
    #1;
    s_rd_valid  = o_rd_valid;
    s_rd_data   = o_rd_data;
    s_wr_ready  = o_wr_ready;
    s_full      = o_full;
    s_empty     = o_empty;
    s_count     = o_count;
    s_mem_wr_en = o_mem_wr_en;
    s_mem_rd_en = o_mem_rd_en;
    s_pushed    = wv && o_wr_ready;
    s_popped    = o_rd_valid && rr;
    chk("full_vs_ready", 32'(o_full), 32'(!o_wr_ready));
    chk("mem_wr_en", 32'(o_mem_wr_en), 32'(s_pushed));
    chk("no_collide", 32'(o_mem_wr_en && o_mem_rd_en && (o_mem_wr_addr == o_mem_rd_addr)), 32'd0);
    if (s_popped) begin
      chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) chk("rd_data", 32'(o_rd_data), 32'(q.pop_front()));
    end
    if (s_pushed) q.push_back(wd);
    @(posedge clk);
  endtask

  initial begin
    int pops;
    int written;
    int ncyc;
    bit seen;

    i_rst      = 1'b0;
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    i_wr_data  = 8'h00;

    // Reset values and 3-cycle write-to-read latency
    do_reset(1'b1);
    cyc(1'b1, 8'h11, 1'b0);
    chk("t1_wr_en_c0", 32'(s_mem_wr_en), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_rd_issue_c1", 32'(s_mem_rd_en), 32'd1);
    chk("t1_valid_c1", 32'(s_rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_valid_c2", 32'(s_rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_valid_c3", 32'(s_rd_valid), 32'd1);
    chk("t1_data_c3", 32'(s_rd_data), 32'h11);
    chk("t1_count_c3", 32'(s_count), 32'd1);
    chk("t1_empty_c3", 32'(s_empty), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t1_popped", 32'(s_popped), 32'd1);

    // Fill to 16 in memory plus 2 in skid
    do_reset(1'b0);
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk("t2_accept", 32'(s_pushed), 32'd1);
    end
    cyc(1'b1, 8'h12, 1'b0);
    chk("t2_full", 32'(s_full), 32'd1);
    chk("t2_wr_ready", 32'(s_wr_ready), 32'd0);
    chk("t2_mem_wr_en", 32'(s_mem_wr_en), 32'd0);
    chk("t2_count", 32'(s_count), 32'd18);

    // Drain from full at one word per cycle
    pops = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      pops += int'(s_popped);
    end
    chk("t3_pops", 32'(pops), 32'd18);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_count", 32'(s_count), 32'd0);
    chk("t3_empty", 32'(s_empty), 32'd1);

    // Continuous push and pop with ascending data
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 8'(i), 1'b1);
      chk("t4_push", 32'(s_pushed), 32'd1);
      if (seen) begin
        chk("t4_nogap", 32'(s_popped), 32'd1);
        chk("t4_count", 32'(s_count), 32'd3);
      end
      if (s_popped) seen = 1'b1;
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("t4_drained", 32'(q.size()), 32'd0);

    // Random backpressure on both sides
    written = 0;
    ncyc    = 0;
    while (written < 1000 && ncyc < 20000) begin
      cyc(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 6));
      written += int'(s_pushed);
      ncyc++;
    end
    chk("t5_written", 32'(written >= 1000), 32'd1);
    ncyc = 0;
    while (q.size() != 0 && ncyc < 100) begin
      cyc(1'b0, 8'h00, 1'b1);
      ncyc++;
    end
    chk("t5_drained", 32'(q.size()), 32'd0);

    // Reset with 5 words held and a read in flight
    do_reset(1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b1, 8'(8'h30 + k), 1'(k == 5 || k == 6));
    @(negedge clk);
    chk("t6_count_before", 32'(o_count), 32'd5);
    chk("t6_valid_before", 32'(o_rd_valid), 32'd1);
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    i_rst      = 1'b1;
    #1;
    chk_reset_vals();
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t6_first_valid", 32'(s_popped), 32'd1);
    chk("t6_first_data", 32'(s_rd_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t6_empty_after", 32'(s_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
